// File: rtl/bec_trace_checker_if.sv
// bec_trace_checker_if
// Groups the observed control word, its sample enable and the checker
// result outputs of bec_trace_checker into one bundle.
//   en, y        : sample enable and 39-bit observed control word (y[i-1] = yi)
//   err/err_code : one-cycle violation pulse and its code
//   err_sticky   : latched violation flag
//   busy         : checker FSM outside IDLE
//   trans_cnt    : completed transactions (wraps)
//   supp_cnt     : suppressed-response events (saturates at 255)
// master: the side that drives the word (bench / controller tap).
// slave : the checker itself.
interface bec_trace_checker_if #(
  parameter int CNT_W = 16
);
  logic             en;
  logic [38:0]      y;
  logic             err;
  logic [2:0]       err_code;
  logic             err_sticky;
  logic             busy;
  logic [CNT_W-1:0] trans_cnt;
  logic [7:0]       supp_cnt;

  modport master (
    output en, y,
    input  err, err_code, err_sticky, busy, trans_cnt, supp_cnt
  );

  modport slave (
    input  en, y,
    output err, err_code, err_sticky, busy, trans_cnt, supp_cnt
  );
endinterface

// File: rtl/bec_trace_checker.sv
// bec_trace_checker
// Passive sequencing checker for the bec controller control-word bus.
// Samples the word on each rising clk edge (when en is high), follows the
// legal transaction sequences with its own FSM and reports illegal starts,
// sequence mismatches, timeouts and suppressed responses after a y4 issue.
// Ports:
//   clk : sampling clock (controller updates on the falling edge)
//   rst : asynchronous active-low reset
//   bus : bec_trace_checker_if.slave (en, y in; err, err_code, err_sticky,
//         busy, trans_cnt, supp_cnt out -- all registered)
module bec_trace_checker #(
  parameter int TIMEOUT = 12,
  parameter int CNT_W   = 16
) (
  input  logic                clk,
  input  logic                rst,
  bec_trace_checker_if.slave  bus
);

  // Counter holds one value past TIMEOUT so a timeout deferred by a
  // same-sample suppressed-response error still fires on the next sample.
  localparam int TW = $clog2(TIMEOUT + 2);

  localparam logic [2:0] E_START   = 3'd1;
  localparam logic [2:0] E_SEQ     = 3'd2;
  localparam logic [2:0] E_TIMEOUT = 3'd3;
  localparam logic [2:0] E_SUPP    = 3'd4;

  // Legal words; bit (i-1) carries controller output yi.
  localparam logic [38:0] W_ZERO  = 39'd0;
  localparam logic [38:0] W_A0    = (39'd1 << 34) | (39'd1 << 35);
  localparam logic [38:0] W_A1    = (39'd1 << 36) | (39'd1 << 37);
  localparam logic [38:0] W_A2    = (39'd1 << 2) | (39'd1 << 27) | (39'd1 << 33);
  localparam logic [38:0] W_B0    = 39'd1;
  localparam logic [38:0] W_B1    = (39'd1 << 1) | (39'd1 << 2);
  localparam logic [38:0] W_B2    = 39'd1 << 38;
  localparam logic [38:0] W_Y34   = 39'd1 << 33;
  localparam logic [38:0] W_R5    = 39'd1 << 4;
  localparam logic [38:0] W_R6_15 = (39'd1 << 5) | (39'd1 << 14);
  localparam logic [38:0] W_R14   = 39'd1 << 13;
  localparam logic [38:0] W_R11   = 39'd1 << 10;
  localparam logic [38:0] W_C13   = 39'd1 << 12;

  typedef enum logic [3:0] {
    ST_IDLE, ST_A1, ST_A2, ST_B1, ST_B2, ST_DEC, ST_S8C, ST_WAIT, ST_C1
  } state_t;

  state_t           state_q, state_d;
  logic [TW-1:0]    tcnt_q, tcnt_d;
  logic             err_q, err_d;
  logic [2:0]       code_q, code_d;
  logic             sticky_q;
  logic             busy_q;
  logic [CNT_W-1:0] trans_q;
  logic [7:0]       supp_q;
  logic             done_d;
  logic             supp_d;
  logic [TW-1:0]    tcnt_inc;

  // Next-state, error classification and timeout decision for one sample.
  always_comb begin
    state_d  = state_q;
    tcnt_d   = tcnt_q;
    err_d    = 1'b0;
    code_d   = code_q;
    done_d   = 1'b0;
    supp_d   = 1'b0;
    tcnt_inc = tcnt_q + TW'(1);
    if (bus.en) begin
      case (state_q)
        ST_IDLE: begin
          if (bus.y == W_ZERO) begin
            state_d = ST_IDLE;
          end else if (bus.y == W_A0) begin
            state_d = ST_A1;
          end else if (bus.y == W_B0) begin
            state_d = ST_B1;
          end else begin
            err_d  = 1'b1;
            code_d = E_START;
          end
        end
        ST_A1: begin
          if (bus.y == W_A1) begin
            state_d = ST_A2;
          end else begin
            err_d = 1'b1; code_d = E_SEQ; state_d = ST_IDLE;
          end
        end
        ST_A2: begin
          if (bus.y == W_A2) begin
            state_d = ST_IDLE; done_d = 1'b1;
          end else begin
            err_d = 1'b1; code_d = E_SEQ; state_d = ST_IDLE;
          end
        end
        ST_B1: begin
          if (bus.y == W_B1) begin
            state_d = ST_B2;
          end else begin
            err_d = 1'b1; code_d = E_SEQ; state_d = ST_IDLE;
          end
        end
        ST_B2: begin
          if (bus.y == W_B2) begin
            state_d = ST_DEC;
          end else begin
            err_d = 1'b1; code_d = E_SEQ; state_d = ST_IDLE;
          end
        end
        ST_DEC: begin
          // y4 takes precedence over every other bit of the decision word.
          if (bus.y[3]) begin
            state_d = ST_S8C;
          end else if ((bus.y == W_ZERO) || (bus.y == W_Y34)) begin
            state_d = ST_IDLE; done_d = 1'b1;
          end else begin
            state_d = ST_WAIT;
          end
        end
        ST_S8C: begin
          if ((bus.y == W_R5) || (bus.y == W_R6_15) ||
              (bus.y == W_R14) || (bus.y == W_R11)) begin
            state_d = ST_WAIT;
          end else if (bus.y == W_ZERO) begin
            // Response suppressed: report it but let the transaction run on.
            err_d = 1'b1; code_d = E_SUPP; supp_d = 1'b1; state_d = ST_WAIT;
          end else begin
            err_d = 1'b1; code_d = E_SEQ; state_d = ST_IDLE;
          end
        end
        ST_WAIT: begin
          if ((bus.y == W_ZERO) || bus.y[33]) begin
            state_d = ST_IDLE; done_d = 1'b1;
          end else if (bus.y[11]) begin
            state_d = ST_C1;
          end else begin
            state_d = ST_WAIT;
          end
        end
        ST_C1: begin
          if (bus.y == W_C13) begin
            state_d = ST_WAIT;
          end else begin
            err_d = 1'b1; code_d = E_SEQ; state_d = ST_IDLE;
          end
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase

      // Timeout: only counts samples taken outside IDLE; any other error
      // on the same sample wins and leaves the timeout for a later sample.
      if (state_d == ST_IDLE) begin
        tcnt_d = '0;
      end else if (state_q == ST_IDLE) begin
        tcnt_d = '0;
      end else if ((tcnt_inc >= TW'(TIMEOUT)) && !err_d) begin
        err_d   = 1'b1;
        code_d  = E_TIMEOUT;
        state_d = ST_IDLE;
        tcnt_d  = '0;
      end else begin
        tcnt_d = tcnt_inc;
      end
    end else begin
      state_d = state_q;
    end
  end

  // FSM state, timeout counter and all registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= ST_IDLE;
      tcnt_q   <= '0;
      err_q    <= 1'b0;
      code_q   <= 3'd0;
      sticky_q <= 1'b0;
      busy_q   <= 1'b0;
      trans_q  <= '0;
      supp_q   <= 8'd0;
    end else begin
      state_q  <= state_d;
      tcnt_q   <= tcnt_d;
      err_q    <= err_d;
      code_q   <= code_d;
      sticky_q <= sticky_q | err_d;
      busy_q   <= (state_d != ST_IDLE);
      if (done_d) begin
        trans_q <= trans_q + CNT_W'(1);
      end
      if (supp_d && (supp_q != 8'd255)) begin
        supp_q <= supp_q + 8'd1;
      end
    end
  end

  assign bus.err        = err_q;
  assign bus.err_code   = code_q;
  assign bus.err_sticky = sticky_q;
  assign bus.busy       = busy_q;
  assign bus.trans_cnt  = trans_q;
  assign bus.supp_cnt   = supp_q;

endmodule

// File: tb/tb_bec_trace_checker.sv
module tb_bec_trace_checker;

  logic clk;
  logic rst;
  int   checks;
  int   failures;
  int   exp_trans;

  bec_trace_checker_if #(.CNT_W(16)) bus ();
  bec_trace_checker_if #(.CNT_W(4))  bus4 ();

  bec_trace_checker #(.TIMEOUT(12), .CNT_W(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Narrow-counter copy watching the same words, used to observe wrap.
  bec_trace_checker #(.TIMEOUT(12), .CNT_W(4)) dut4 (
    .clk (clk),
    .rst (rst),
    .bus (bus4)
  );

  assign bus4.en = bus.en;
  assign bus4.y  = bus.y;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Word with the listed controller outputs yi set (0 = unused slot).
  function automatic logic [38:0] yw(input int a = 0, input int b = 0, input int c = 0);
    logic [38:0] w;
    w = 39'd0;
    if (a > 0) w[a-1] = 1'b1;
    if (b > 0) w[b-1] = 1'b1;
    if (c > 0) w[c-1] = 1'b1;
    return w;
  endfunction

  task automatic step(input logic [38:0] w);
    @(negedge clk);
    bus.y  = w;
    bus.en = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b0; bus.en = 1'b0; bus.y = 39'd0;
    #3;
    checks++; if (bus.err !== 1'b0)        begin failures++; $display("FAIL reset_err got %0b want 0", bus.err); end
    checks++; if (bus.err_code !== 3'd0)   begin failures++; $display("FAIL reset_code got %0d want 0", bus.err_code); end
    checks++; if (bus.err_sticky !== 1'b0) begin failures++; $display("FAIL reset_sticky got %0b want 0", bus.err_sticky); end
    checks++; if (bus.busy !== 1'b0)       begin failures++; $display("FAIL reset_busy got %0b want 0", bus.busy); end
    checks++; if (bus.trans_cnt !== 16'd0) begin failures++; $display("FAIL reset_trans got %0d want 0", bus.trans_cnt); end
    checks++; if (bus.supp_cnt !== 8'd0)   begin failures++; $display("FAIL reset_supp got %0d want 0", bus.supp_cnt); end
    @(negedge clk); @(negedge clk);
    rst = 1'b1;
    exp_trans = 0;
  endtask

  task automatic test_seq_a;
    logic [38:0] w [4];
    logic        eb [4];
    w[0] = yw(35, 36); w[1] = yw(37, 38); w[2] = yw(3, 28, 34); w[3] = 39'd0;
    eb[0] = 1'b1; eb[1] = 1'b1; eb[2] = 1'b0; eb[3] = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step(w[i]);
      checks++; if (bus.busy !== eb[i]) begin failures++; $display("FAIL seqa_busy[%0d] got %0b want %0b", i, bus.busy, eb[i]); end
      checks++; if (bus.err !== 1'b0)   begin failures++; $display("FAIL seqa_err[%0d] got %0b want 0", i, bus.err); end
    end
    exp_trans++;
    checks++; if (bus.trans_cnt !== 16'(exp_trans)) begin failures++; $display("FAIL seqa_trans got %0d want %0d", bus.trans_cnt, exp_trans); end
    checks++; if (bus.err_sticky !== 1'b0) begin failures++; $display("FAIL seqa_sticky got %0b want 0", bus.err_sticky); end
  endtask

  // B chain; when supp is set the response after {4} is suppressed.
  task automatic run_b_chain(input bit supp, input bit chk, input int tag);
    logic [38:0] w [8];
    w[0] = yw(1); w[1] = yw(2, 3); w[2] = yw(39); w[3] = yw(4);
    w[4] = supp ? 39'd0 : yw(5);
    w[5] = yw(12); w[6] = yw(13); w[7] = yw(34);
    for (int i = 0; i < 8; i++) begin
      step(w[i]);
      if (chk) begin
        if (supp && i == 4) begin
          checks++; if (bus.err !== 1'b1 || bus.err_code !== 3'd4) begin failures++; $display("FAIL supp_err[%0d] got err=%0b code=%0d want err=1 code=4", tag, bus.err, bus.err_code); end
          checks++; if (bus.busy !== 1'b1) begin failures++; $display("FAIL supp_busy[%0d] got %0b want 1", tag, bus.busy); end
        end else begin
          checks++; if (bus.err !== 1'b0) begin failures++; $display("FAIL bchain_err[%0d.%0d] got %0b want 0", tag, i, bus.err); end
        end
      end
    end
    exp_trans++;
  endtask

  task automatic test_seq_b;
    run_b_chain(1'b0, 1'b1, 0);
    checks++; if (bus.trans_cnt !== 16'(exp_trans)) begin failures++; $display("FAIL seqb_trans got %0d want %0d", bus.trans_cnt, exp_trans); end
    checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL seqb_busy got %0b want 0", bus.busy); end
  endtask

  task automatic test_suppressed;
    run_b_chain(1'b1, 1'b1, 1);
    checks++; if (bus.supp_cnt !== 8'd1) begin failures++; $display("FAIL supp_cnt1 got %0d want 1", bus.supp_cnt); end
    checks++; if (bus.trans_cnt !== 16'(exp_trans)) begin failures++; $display("FAIL supp_trans got %0d want %0d", bus.trans_cnt, exp_trans); end
    for (int k = 2; k <= 300; k++) begin
      run_b_chain(1'b1, (k == 255 || k == 256 || k == 300), k);
    end
    checks++; if (bus.supp_cnt !== 8'd255) begin failures++; $display("FAIL supp_sat got %0d want 255", bus.supp_cnt); end
    checks++; if (bus.trans_cnt !== 16'(exp_trans)) begin failures++; $display("FAIL supp_trans300 got %0d want %0d", bus.trans_cnt, exp_trans); end
  endtask

  task automatic test_mismatch;
    step(yw(35, 36));
    step(yw(37));
    checks++; if (bus.err !== 1'b1 || bus.err_code !== 3'd2) begin failures++; $display("FAIL mismatch got err=%0b code=%0d want err=1 code=2", bus.err, bus.err_code); end
    checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL mismatch_busy got %0b want 0", bus.busy); end
    step(yw(7));
    checks++; if (bus.err !== 1'b1 || bus.err_code !== 3'd1) begin failures++; $display("FAIL illegal_start got err=%0b code=%0d want err=1 code=1", bus.err, bus.err_code); end
    step(39'd0);
    checks++; if (bus.err !== 1'b0) begin failures++; $display("FAIL err_pulse got %0b want 0", bus.err); end
    checks++; if (bus.err_code !== 3'd1) begin failures++; $display("FAIL code_hold got %0d want 1", bus.err_code); end
    checks++; if (bus.err_sticky !== 1'b1) begin failures++; $display("FAIL sticky got %0b want 1", bus.err_sticky); end
  endtask

  task automatic test_timeout;
    logic       we;
    logic [2:0] wc;
    logic       wb;
    step(yw(1)); step(yw(2, 3)); step(yw(39));
    // Samples so far outside IDLE: {2,3}, {39}; the 10th {3} is the 12th.
    for (int i = 0; i < 20; i++) begin
      step(yw(3));
      if (i < 9) begin
        we = 1'b0; wc = 3'd1; wb = 1'b1;
      end else if (i == 9) begin
        we = 1'b1; wc = 3'd3; wb = 1'b0;
      end else begin
        we = 1'b1; wc = 3'd1; wb = 1'b0;
      end
      checks++;
      if (bus.err !== we || bus.busy !== wb || (we && bus.err_code !== wc)) begin
        failures++;
        $display("FAIL timeout[%0d] got err=%0b code=%0d busy=%0b want err=%0b code=%0d busy=%0b", i, bus.err, bus.err_code, bus.busy, we, wc, wb);
      end
    end
    step(39'd0);
    step(yw(7));
    checks++; if (bus.err !== 1'b1 || bus.err_code !== 3'd1) begin failures++; $display("FAIL after_timeout got err=%0b code=%0d want err=1 code=1", bus.err, bus.err_code); end
  endtask

  task automatic test_reset_mid;
    step(yw(1)); step(yw(2, 3));
    checks++; if (bus.busy !== 1'b1) begin failures++; $display("FAIL rmid_busy_pre got %0b want 1", bus.busy); end
    @(negedge clk);
    #1 rst = 1'b0;
    #1;
    exp_trans = 0;
    checks++; if (bus.busy !== 1'b0)       begin failures++; $display("FAIL rmid_busy got %0b want 0", bus.busy); end
    checks++; if (bus.err_sticky !== 1'b0) begin failures++; $display("FAIL rmid_sticky got %0b want 0", bus.err_sticky); end
    checks++; if (bus.err_code !== 3'd0)   begin failures++; $display("FAIL rmid_code got %0d want 0", bus.err_code); end
    checks++; if (bus.trans_cnt !== 16'd0) begin failures++; $display("FAIL rmid_trans got %0d want 0", bus.trans_cnt); end
    checks++; if (bus.supp_cnt !== 8'd0)   begin failures++; $display("FAIL rmid_supp got %0d want 0", bus.supp_cnt); end
    checks++; if (bus.err !== 1'b0)        begin failures++; $display("FAIL rmid_err got %0b want 0", bus.err); end
    #1 rst = 1'b1;
    step(yw(39));
    checks++; if (bus.err !== 1'b1 || bus.err_code !== 3'd1) begin failures++; $display("FAIL rmid_after got err=%0b code=%0d want err=1 code=1", bus.err, bus.err_code); end
  endtask

  task automatic test_enable;
    int bad;
    step(yw(35, 36));
    bad = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      bus.en = 1'b0;
      bus.y  = yw(7);
      @(posedge clk);
      #1;
      if (bus.err !== 1'b0 || bus.busy !== 1'b1) bad++;
    end
    checks++; if (bad !== 0) begin failures++; $display("FAIL en_hold got %0d bad samples want 0", bad); end
    step(yw(37, 38));
    checks++; if (bus.err !== 1'b0 || bus.busy !== 1'b1) begin failures++; $display("FAIL en_resume got err=%0b busy=%0b want err=0 busy=1", bus.err, bus.busy); end
    step(yw(3, 28, 34));
    exp_trans++;
    checks++; if (bus.err !== 1'b0) begin failures++; $display("FAIL en_done_err got %0b want 0", bus.err); end
    checks++; if (bus.trans_cnt !== 16'(exp_trans)) begin failures++; $display("FAIL en_trans got %0d want %0d", bus.trans_cnt, exp_trans); end
  endtask

  task automatic test_wrap;
    logic [3:0] e4;
    for (int i = 0; i < 20; i++) begin
      step(yw(35, 36)); step(yw(37, 38)); step(yw(3, 28, 34));
      exp_trans++;
      e4 = 4'(exp_trans);
      checks++; if (bus4.trans_cnt !== e4) begin failures++; $display("FAIL wrap4[%0d] got %0d want %0d", i, bus4.trans_cnt, e4); end
    end
    checks++; if (bus.trans_cnt !== 16'(exp_trans)) begin failures++; $display("FAIL wrap16 got %0d want %0d", bus.trans_cnt, exp_trans); end
  endtask

  initial begin
    checks = 0; failures = 0; exp_trans = 0;
    bus.en = 1'b0; bus.y = 39'd0;
    test_reset;
    test_seq_a;
    test_seq_b;
    test_suppressed;
    test_mismatch;
    test_timeout;
    test_reset_mid;
    test_enable;
    test_wrap;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
